// File: rtl/pipeline_hazard_controller.sv
// Pipeline hazard controller: resolves memory waits, multi-cycle mul/div, taken branches and
// load-use hazards into per-register stall/flush controls, and counts PC stall cycles.
module pipeline_hazard_controller #(
    parameter int MULDIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  Reg1Dec,
    input  logic [4:0]  Reg2Dec,
    input  logic        UsesReg1Dec,
    input  logic        UsesReg2Dec,
    input  logic        MemReadExePipe,
    input  logic [4:0]  WriteBackRegExePipe,
    input  logic        MulDivStartExe,
    input  logic        BranchTakenExe,
    input  logic        DataMemReqMem,
    input  logic        DataMemReady,
    output logic        StallPC,
    output logic        StallIFID,
    output logic        StallIDEX,
    output logic        StallEXMEM,
    output logic        FlushIFID,
    output logic        FlushIDEX,
    output logic        FlushEXMEM,
    output logic        FlushMEMWB,
    output logic        MulDivBusy,
    output logic        MulDivDone,
    output logic [31:0] StallCycleCount
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [5:0] CNT_LOAD = 6'(MULDIV_CYCLES - 1);

    state_t      state_r;
    state_t      state_s;
    logic [5:0]  cnt_r;
    logic [5:0]  cnt_s;
    logic        busy_r;
    logic        done_r;
    logic [31:0] stall_cnt_r;
    logic        mem_wait_s;
    logic        load_use_s;
    logic        muldiv_hold_s;

    assign mem_wait_s = DataMemReqMem & ~DataMemReady;
    assign load_use_s = MemReadExePipe & (WriteBackRegExePipe != 5'd0) &
                        ((UsesReg1Dec & (WriteBackRegExePipe == Reg1Dec)) |
                         (UsesReg2Dec & (WriteBackRegExePipe == Reg2Dec)));
    // DONE ignores MulDivStartExe: the finished instruction is still visible in EX for that cycle
    assign muldiv_hold_s = (state_r == ST_BUSY) | ((state_r == ST_RUN) & MulDivStartExe);

    // Mul/div sequencer next-state and counter; the countdown continues under a memory wait
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            ST_RUN: begin
                if (MulDivStartExe && !mem_wait_s) begin
                    state_s = ST_BUSY;
                    cnt_s   = CNT_LOAD;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_BUSY: begin
                if (cnt_r <= 6'd1) begin
                    state_s = ST_DONE;
                    cnt_s   = 6'd0;
                end else begin
                    cnt_s   = cnt_r - 6'd1;
                end
            end
            ST_DONE: begin
                state_s = ST_RUN;
            end
            default: begin
                state_s = ST_RUN;
                cnt_s   = 6'd0;
            end
        endcase
    end

    // Hazard priority: memory wait, mul/div hold, taken branch, load-use; all forced low in reset
    always_comb begin
        StallPC    = 1'b0;
        StallIFID  = 1'b0;
        StallIDEX  = 1'b0;
        StallEXMEM = 1'b0;
        FlushIFID  = 1'b0;
        FlushIDEX  = 1'b0;
        FlushEXMEM = 1'b0;
        FlushMEMWB = 1'b0;
        if (!rst_n) begin
            StallPC = 1'b0;
        end else if (mem_wait_s) begin
            StallPC    = 1'b1;
            StallIFID  = 1'b1;
            StallIDEX  = 1'b1;
            StallEXMEM = 1'b1;
            FlushMEMWB = 1'b1;
        end else if (muldiv_hold_s) begin
            StallPC    = 1'b1;
            StallIFID  = 1'b1;
            StallIDEX  = 1'b1;
            FlushEXMEM = 1'b1;
        end else if (BranchTakenExe) begin
            FlushIFID  = 1'b1;
            FlushIDEX  = 1'b1;
        end else if (load_use_s) begin
            StallPC    = 1'b1;
            StallIFID  = 1'b1;
            FlushIDEX  = 1'b1;
        end else begin
            StallPC = 1'b0;
        end
    end

    // State, counter and status flags; busy/done mirror the state being entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_RUN;
            cnt_r   <= 6'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            busy_r  <= (state_s == ST_BUSY);
            done_r  <= (state_s == ST_DONE);
        end
    end

    // Saturating count of PC stall cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= 32'd0;
        end else if (StallPC && (stall_cnt_r != 32'hFFFF_FFFF)) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign MulDivBusy      = busy_r;
    assign MulDivDone      = done_r;
    assign StallCycleCount = stall_cnt_r;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench for pipeline_hazard_controller: table of single-cycle hazard vectors plus
// multi-cycle mul/div, memory-wait, reset and counter-saturation sequences, via a scoreboard queue.
module tb_pipeline_hazard_controller;

    logic        clk;
    logic        rst_n;
    logic [4:0]  Reg1Dec, Reg2Dec, WriteBackRegExePipe;
    logic        UsesReg1Dec, UsesReg2Dec, MemReadExePipe, MulDivStartExe, BranchTakenExe;
    logic        DataMemReqMem, DataMemReady;
    logic        StallPC, StallIFID, StallIDEX, StallEXMEM;
    logic        FlushIFID, FlushIDEX, FlushEXMEM, FlushMEMWB;
    logic        MulDivBusy, MulDivDone;
    logic [31:0] StallCycleCount;

    pipeline_hazard_controller #(.MULDIV_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .Reg1Dec(Reg1Dec), .Reg2Dec(Reg2Dec),
        .UsesReg1Dec(UsesReg1Dec), .UsesReg2Dec(UsesReg2Dec),
        .MemReadExePipe(MemReadExePipe), .WriteBackRegExePipe(WriteBackRegExePipe),
        .MulDivStartExe(MulDivStartExe), .BranchTakenExe(BranchTakenExe),
        .DataMemReqMem(DataMemReqMem), .DataMemReady(DataMemReady),
        .StallPC(StallPC), .StallIFID(StallIFID), .StallIDEX(StallIDEX), .StallEXMEM(StallEXMEM),
        .FlushIFID(FlushIFID), .FlushIDEX(FlushIDEX), .FlushEXMEM(FlushEXMEM), .FlushMEMWB(FlushMEMWB),
        .MulDivBusy(MulDivBusy), .MulDivDone(MulDivDone), .StallCycleCount(StallCycleCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output vector layout: {StallPC, StallIFID, StallIDEX, StallEXMEM,
    //                        FlushIFID, FlushIDEX, FlushEXMEM, FlushMEMWB, MulDivBusy, MulDivDone}
    localparam logic [9:0] E_NONE = 10'b0000_0000_00;
    localparam logic [9:0] E_LU   = 10'b1100_0100_00;
    localparam logic [9:0] E_BR   = 10'b0000_1100_00;
    localparam logic [9:0] E_MW   = 10'b1111_0001_00;
    localparam logic [9:0] E_MD   = 10'b1110_0010_00;
    localparam logic [9:0] E_MDB  = 10'b1110_0010_10;
    localparam logic [9:0] E_MWB  = 10'b1111_0001_10;
    localparam logic [9:0] E_DONE = 10'b0000_0000_01;
    localparam logic [9:0] E_BRD  = 10'b0000_1100_01;

    typedef struct packed {
        logic [4:0] r1;
        logic       u1;
        logic [4:0] r2;
        logic       u2;
        logic       mrd;
        logic [4:0] wb;
        logic       st;
        logic       br;
        logic       req;
        logic       rdy;
        logic [9:0] exp;
    } vec_t;

    vec_t        vecs[15];
    vec_t        sb_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] model_cnt = 32'd0;

    function automatic vec_t mk(input logic [4:0] r1, input logic u1, input logic [4:0] r2,
                                input logic u2, input logic mrd, input logic [4:0] wb,
                                input logic st, input logic br, input logic req, input logic rdy,
                                input logic [9:0] exp);
        vec_t v;
        v.r1 = r1; v.u1 = u1; v.r2 = r2; v.u2 = u2; v.mrd = mrd; v.wb = wb;
        v.st = st; v.br = br; v.req = req; v.rdy = rdy; v.exp = exp;
        return v;
    endfunction

    function automatic logic [9:0] outs();
        return {StallPC, StallIFID, StallIDEX, StallEXMEM,
                FlushIFID, FlushIDEX, FlushEXMEM, FlushMEMWB, MulDivBusy, MulDivDone};
    endfunction

    task automatic drive(input vec_t v);
        Reg1Dec = v.r1; UsesReg1Dec = v.u1; Reg2Dec = v.r2; UsesReg2Dec = v.u2;
        MemReadExePipe = v.mrd; WriteBackRegExePipe = v.wb; MulDivStartExe = v.st;
        BranchTakenExe = v.br; DataMemReqMem = v.req; DataMemReady = v.rdy;
    endtask

    // Drive one cycle at the falling edge, queue its expectation, compare mid-cycle
    task automatic apply(input string tag, input vec_t v);
        vec_t e;
        logic [9:0] act;
        @(negedge clk);
        drive(v);
        sb_q.push_back(v);
        #2;
        e   = sb_q.pop_front();
        act = outs();
        checks++;
        if (act !== e.exp) begin
            errors++;
            $display("FAIL %s: outputs got %b expected %b", tag, act, e.exp);
        end
        if (e.exp[9] && model_cnt != 32'hFFFF_FFFF) model_cnt = model_cnt + 32'd1;
    endtask

    task automatic check_cnt(input string tag);
        @(posedge clk);
        #1;
        checks++;
        if (StallCycleCount !== model_cnt) begin
            errors++;
            $display("FAIL %s: StallCycleCount got %h expected %h", tag, StallCycleCount, model_cnt);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t idle, st, stw;
        idle = mk(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE);
        vecs[0]  = idle;
        vecs[1]  = mk(5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, E_LU);
        vecs[2]  = idle;
        vecs[3]  = mk(5'd3, 1'b0, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, E_LU);
        vecs[4]  = mk(5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE);
        vecs[5]  = mk(5'd7, 1'b0, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE);
        vecs[6]  = mk(5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE);
        vecs[7]  = mk(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, E_BR);
        vecs[8]  = mk(5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, E_BR);
        vecs[9]  = mk(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, E_MW);
        vecs[10] = mk(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, E_NONE);
        vecs[11] = mk(5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0, E_MW);
        vecs[12] = mk(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, E_MW);
        vecs[13] = idle;
        vecs[14] = mk(5'd5, 1'b1, 5'd6, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE);
        st  = mk(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, E_MD);
        stw = mk(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, E_MWB);

        // Reset: inputs that would otherwise stall must not reach the outputs
        rst_n = 1'b0;
        drive(vecs[11]);
        #12;
        checks++;
        if (outs() !== E_NONE || StallCycleCount !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: outputs got %b cnt %h expected %b cnt 0", outs(), StallCycleCount, E_NONE);
        end
        @(negedge clk);
        drive(idle);
        rst_n = 1'b1;

        // Single load-use bubble, then clear, one stall counted
        apply("lu_bubble", vecs[1]);
        apply("lu_clear", idle);
        check_cnt("lu_count");

        for (int i = 0; i < 15; i++) apply($sformatf("vec%0d", i), vecs[i]);
        check_cnt("table_count");

        // Mul/div with start held: start cycle, 3 BUSY, DONE with start ignored
        apply("md_start", st);
        for (int i = 0; i < 3; i++) apply($sformatf("md_busy%0d", i), mk(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, E_MDB));
        apply("md_done", mk(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, E_DONE));
        apply("md_after", idle);
        check_cnt("md_count");

        // Memory wait covering the last two BUSY cycles; DONE timing unchanged
        apply("mw_start", st);
        apply("mw_busy0", mk(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, E_MDB));
        apply("mw_wait0", stw);
        apply("mw_wait1", stw);
        apply("mw_done", mk(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, E_DONE));
        apply("mw_after", idle);
        check_cnt("mw_count");

        // Branch held behind mul/div fires in DONE
        apply("br_start", mk(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, E_MD));
        for (int i = 0; i < 3; i++) apply($sformatf("br_busy%0d", i), mk(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, E_MDB));
        apply("br_done", mk(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, E_BRD));
        apply("br_after", idle);

        // Reset mid-BUSY: outputs drop at once, no DONE pulse afterwards
        apply("rst_start", st);
        apply("rst_busy", mk(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, E_MDB));
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (outs() !== E_NONE || StallCycleCount !== 32'd0) begin
            errors++;
            $display("FAIL rst_mid_busy: outputs got %b cnt %h expected %b cnt 0", outs(), StallCycleCount, E_NONE);
        end
        model_cnt = 32'd0;
        @(negedge clk);
        drive(idle);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) apply($sformatf("rst_after%0d", i), idle);

        // Saturation from 0xFFFFFFFE
        @(negedge clk);
        force dut.stall_cnt_r = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt_r;
        model_cnt = 32'hFFFF_FFFE;
        for (int i = 0; i < 3; i++) apply($sformatf("sat%0d", i), vecs[9]);
        check_cnt("sat_count");
        checks++;
        if (StallCycleCount !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL sat_value: StallCycleCount got %h expected ffffffff", StallCycleCount);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_controller.md
PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 Parameter MULDIV_CYCLES, default 32: EX-stage cycles a multiply/divide occupies; legal range 2..64.
REQ-002 clk  in  1  sole clock; all state updates on the rising edge.
REQ-003 rst_n  in  1  reset, asynchronous assertion, active-low.
REQ-004 Reg1Dec, Reg2Dec  in  5 each  ID-stage source register indices.
REQ-005 UsesReg1Dec, UsesReg2Dec  in  1 each  ID instruction actually reads Reg1Dec/Reg2Dec.
REQ-006 MemReadExePipe  in  1  EX-stage instruction is a load.
REQ-007 WriteBackRegExePipe  in  5  EX-stage destination index.
REQ-008 MulDivStartExe  in  1  EX-stage instruction is mul/div (level, held while EX is held).
REQ-009 BranchTakenExe  in  1  EX-stage branch/jump redirects the PC this cycle.
REQ-010 DataMemReqMem, DataMemReady  in  1 each  MEM-stage access pending / data memory completes it this cycle.
REQ-011 StallPC, StallIFID, StallIDEX, StallEXMEM  out  1 each  hold the named register.
REQ-012 FlushIFID, FlushIDEX, FlushEXMEM, FlushMEMWB  out  1 each  load a bubble into the named register.
REQ-013 MulDivBusy  out  1  registered; high while the FSM is in BUSY.
REQ-014 MulDivDone  out  1  registered; one-cycle pulse, high while the FSM is in DONE.
REQ-015 StallCycleCount  out  32  saturating count of cycles with StallPC high.

Function
REQ-016 FSM states: RUN, BUSY, DONE; the cycle counter is 6 bits.
REQ-017 RUN -> BUSY when MulDivStartExe=1 and MemWait=0; the counter loads MULDIV_CYCLES-1.
REQ-018 BUSY: the counter decrements each cycle; at counter=1 the next state is DONE.
REQ-019 DONE -> RUN unconditionally; MulDivStartExe is ignored in DONE, because the same instruction leaves EX.
REQ-020 MemWait = DataMemReqMem & !DataMemReady, combinational.
REQ-021 LoadUse = MemReadExePipe & WriteBackRegExePipe!=0 & ((UsesReg1Dec & WriteBackRegExePipe==Reg1Dec) | (UsesReg2Dec & WriteBackRegExePipe==Reg2Dec)).
REQ-022 The controller applies the following priority, all outputs combinational from state and inputs:
  - P1 MemWait: StallPC, StallIFID, StallIDEX, StallEXMEM=1; FlushMEMWB=1; every other output 0.
  - P2 state BUSY, or RUN with MulDivStartExe: StallPC, StallIFID, StallIDEX=1; FlushEXMEM=1.
  - P3 BranchTakenExe (RUN or DONE): FlushIFID, FlushIDEX=1; StallPC=0.
  - P4 LoadUse: StallPC, StallIFID=1; FlushIDEX=1 (exactly one bubble, no state).
  - Otherwise all stall/flush outputs are 0.
REQ-023 The BUSY counter keeps decrementing while MemWait=1; when BUSY reaches DONE under MemWait, the FSM enters DONE and the MulDivDone pulse still occurs.
REQ-024 A branch suppressed by P1/P2 takes effect on the first cycle that P1/P2 release, because EX is held.
REQ-025 LoadUse with Rd=x0 never stalls.
REQ-026 StallCycleCount increments by 1 on each edge where StallPC=1 and holds at 0xFFFFFFFF.

Reset
REQ-027 While rst_n=0, all of the following hold:
  - The state is RUN, the counter is 0, and StallCycleCount is 0.
  - MulDivBusy and MulDivDone are 0.
  - All stall/flush outputs are forced 0.
REQ-028 Reset asserted in BUSY aborts the operation, with no MulDivDone pulse.
REQ-029 Following rst_n deassertion, the first edge evaluates state RUN.

Verification
REQ-030 Load-use: MemReadExePipe=1, WriteBackRegExePipe=5, Reg1Dec=5, UsesReg1Dec=1 -> one cycle of StallPC=StallIFID=FlushIDEX=1; next cycle all 0; StallCycleCount=1.
REQ-031 MulDiv with MULDIV_CYCLES=4, MulDivStartExe held:
  - Stalls and FlushEXMEM are high in the start cycle and for the 3 BUSY cycles.
  - MulDivBusy is high for 3 cycles.
  - MulDivDone pulses once in the 5th cycle, with all stalls 0.
  - StallCycleCount=4.
REQ-032 Branch during load-use: BranchTakenExe=1 with LoadUse=1 -> FlushIFID=FlushIDEX=1, StallPC=0.
REQ-033 MemWait during BUSY: DataMemReqMem=1, DataMemReady=0 for 2 cycles mid-BUSY -> StallEXMEM=FlushMEMWB=1 during those cycles, with FlushEXMEM=0 and MulDivDone timing unchanged.
REQ-034 Reset mid-BUSY: rst_n=0 asynchronously -> outputs 0 immediately; after release, state RUN with no MulDivDone pulse.
REQ-035 Saturation: force StallCycleCount to 0xFFFFFFFE and apply 3 stall cycles -> the count reads 0xFFFFFFFF.
